// File: rtl/pitch_seq_unit_tx_if.sv
// Command and output-stream bundle for pitch_seq_unit_tx.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where the producer's valid and the consumer's ready are both high. A producer
// holds valid and payload steady until that edge; ready may move freely and is
// never a precondition for asserting valid.
//   command channel : in_cmd_valid / out_cmd_ready   (upstream -> block)
//   stream channel  : out_data_valid / in_ready_for_udp_output (block -> UDP)
// out_error is a bare one-cycle pulse with no handshake.
interface pitch_seq_unit_tx_if;
  logic        in_cmd_valid;
  logic        out_cmd_ready;
  logic [7:0]  in_cmd_type;
  logic [7:0]  in_unit;
  logic [31:0] in_seconds_u32;
  logic [31:0] in_time_offset_u32;
  logic [63:0] in_order_id_u64;

  logic [63:0] out_bytes;
  logic [7:0]  out_byte_enables;
  logic        out_data_valid;
  logic        in_ready_for_udp_output;
  logic        out_error;

  // Upstream command source and downstream UDP sink.
  modport master (
    output in_cmd_valid, in_cmd_type, in_unit, in_seconds_u32,
           in_time_offset_u32, in_order_id_u64, in_ready_for_udp_output,
    input  out_cmd_ready, out_bytes, out_byte_enables, out_data_valid,
           out_error
  );

  // The encoder itself.
  modport slave (
    input  in_cmd_valid, in_cmd_type, in_unit, in_seconds_u32,
           in_time_offset_u32, in_order_id_u64, in_ready_for_udp_output,
    output out_cmd_ready, out_bytes, out_byte_enables, out_data_valid,
           out_error
  );
endinterface

// File: rtl/pitch_seq_unit_tx.sv
// pitch_seq_unit_tx: encodes one command into one PITCH Sequenced Unit
// (8-byte header + one Time or Delete Order message), streamed as 64-bit
// words with byte 0 in [63:56]. All multi-byte fields are little-endian.
//
// Optional feature: define PITCH_TX_DEBUG_EN to add a per-packet debug word
// port (out_debug_valid / out_debug_element / in_ready_for_debug).
//
// seq_load / seq_load_value preset the sequence counter while idle, so the
// wrap at 0xFFFFFFFF can be reached without sending four billion packets.
// fsm_state exposes the packet state (0 IDLE, 1 HDR, 2 W1, 3 W2).
module pitch_seq_unit_tx (
  input  logic        Clk40,
  input  logic        reset,
  pitch_seq_unit_tx_if.slave bus,
  input  logic        seq_load,
  input  logic [31:0] seq_load_value,
  output logic [1:0]  fsm_state
`ifdef PITCH_TX_DEBUG_EN
  ,
  output logic        out_debug_valid,
  output logic [63:0] out_debug_element,
  input  logic        in_ready_for_debug
`endif
);

  localparam logic [7:0]  TYPE_TIME   = 8'h20;
  localparam logic [7:0]  TYPE_DELETE = 8'h29;
  localparam logic [15:0] LEN_TIME    = 16'd14;
  localparam logic [15:0] LEN_DELETE  = 16'd22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Command fields frozen at accept so later input changes cannot leak in.
  logic [7:0]  type_q;
  logic [7:0]  unit_q;
  logic [31:0] seconds_q;
  logic [31:0] offset_q;
  logic [63:0] order_id_q;

  logic [31:0] seq_q;
  logic        error_q;

  logic        cmd_ready;
  logic        accept;
  logic        type_ok;
  logic        data_valid;
  logic        xfer;
  logic        last_xfer;
  logic [15:0] pkt_len;
  logic [63:0] word;
  logic [7:0]  enables;

  assign type_ok = (bus.in_cmd_type == TYPE_TIME) ||
                   (bus.in_cmd_type == TYPE_DELETE);
  assign pkt_len = (type_q == TYPE_DELETE) ? LEN_DELETE : LEN_TIME;

  // Next-state and handshake decode. Reset gates both ready and valid so the
  // block shows nothing while reset is held.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    data_valid = 1'b0;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !reset;
        accept    = bus.in_cmd_valid && cmd_ready;
        if (accept && type_ok) begin
          state_d = HDR;
        end
      end
      HDR: begin
        data_valid = !reset;
        xfer       = data_valid && bus.in_ready_for_udp_output;
        if (xfer) begin
          state_d = W1;
        end
      end
      W1: begin
        data_valid = !reset;
        xfer       = data_valid && bus.in_ready_for_udp_output;
        if (xfer) begin
          if (type_q == TYPE_DELETE) begin
            state_d = W2;
          end else begin
            state_d   = IDLE;
            last_xfer = 1'b1;
          end
        end
      end
      W2: begin
        data_valid = !reset;
        xfer       = data_valid && bus.in_ready_for_udp_output;
        if (xfer) begin
          state_d   = IDLE;
          last_xfer = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word formatter: pure function of state and frozen fields, so the word is
  // naturally stable while downstream stalls, and zero whenever not valid.
  always_comb begin
    word    = 64'h0;
    enables = 8'h00;
    if (data_valid) begin
      case (state_q)
        HDR: begin
          word    = {pkt_len[7:0], pkt_len[15:8], 8'h01, unit_q,
                     seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
          enables = 8'hFF;
        end
        W1: begin
          if (type_q == TYPE_DELETE) begin
            word    = {8'h0E, TYPE_DELETE,
                       offset_q[7:0], offset_q[15:8],
                       offset_q[23:16], offset_q[31:24],
                       order_id_q[7:0], order_id_q[15:8]};
            enables = 8'hFF;
          end else begin
            word    = {8'h06, TYPE_TIME,
                       seconds_q[7:0], seconds_q[15:8],
                       seconds_q[23:16], seconds_q[31:24],
                       16'h0000};
            enables = 8'hFC;
          end
        end
        W2: begin
          word    = {order_id_q[23:16], order_id_q[31:24],
                     order_id_q[39:32], order_id_q[47:40],
                     order_id_q[55:48], order_id_q[63:56],
                     16'h0000};
          enables = 8'hFC;
        end
        default: begin
          word    = 64'h0;
          enables = 8'h00;
        end
      endcase
    end
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge Clk40) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the command payload on every accept.
  always_ff @(posedge Clk40) begin
    if (reset) begin
      type_q     <= 8'h00;
      unit_q     <= 8'h00;
      seconds_q  <= 32'h0;
      offset_q   <= 32'h0;
      order_id_q <= 64'h0;
    end else if (accept) begin
      type_q     <= bus.in_cmd_type;
      unit_q     <= bus.in_unit;
      seconds_q  <= bus.in_seconds_u32;
      offset_q   <= bus.in_time_offset_u32;
      order_id_q <= bus.in_order_id_u64;
    end
  end

  // Sequence counter: advances once per completed packet and skips 0 on wrap.
  always_ff @(posedge Clk40) begin
    if (reset) begin
      seq_q <= 32'd1;
    end else if (last_xfer) begin
      seq_q <= (seq_q == 32'hFFFF_FFFF) ? 32'd1 : seq_q + 32'd1;
    end else if (seq_load && (state_q == IDLE)) begin
      seq_q <= seq_load_value;
    end
  end

  // One-cycle error pulse for a command of unsupported type.
  always_ff @(posedge Clk40) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= accept && !type_ok;
    end
  end

  assign bus.out_cmd_ready    = cmd_ready;
  assign bus.out_data_valid   = data_valid;
  assign bus.out_bytes        = word;
  assign bus.out_byte_enables = enables;
  assign bus.out_error        = error_q && !reset;
  assign fsm_state            = state_q;

`ifdef PITCH_TX_DEBUG_EN
  logic        dbg_valid_q;
  logic [63:0] dbg_elem_q;

  // Debug word per completed packet; a newer completion replaces a pending one.
  always_ff @(posedge Clk40) begin
    if (reset) begin
      dbg_valid_q <= 1'b0;
      dbg_elem_q  <= 64'h0;
    end else if (last_xfer) begin
      dbg_valid_q <= 1'b1;
      dbg_elem_q  <= {seq_q, 8'h00, type_q, pkt_len};
    end else if (dbg_valid_q && in_ready_for_debug) begin
      dbg_valid_q <= 1'b0;
    end
  end

  assign out_debug_valid   = dbg_valid_q;
  assign out_debug_element = dbg_elem_q;
`else
  // No debug capture in this build.
`endif

endmodule

// File: doc/pitch_seq_unit_tx.md
PITCH_SEQ_UNIT_TX -- requirements
Module: pitch_seq_unit_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
- Clk40  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL have these command ports:
- in_cmd_valid  in  1  command present.
- out_cmd_ready  out  1  command accepted when both valid and ready are high.
- in_cmd_type  in  8  PITCH message type: 0x20 Time, 0x29 Delete Order.
- in_unit  in  8  unit number for the header.
- in_seconds_u32  in  32  Time message seconds.
- in_time_offset_u32  in  32  Delete Order time offset in ns.
- in_order_id_u64  in  64  Delete Order order id.
REQ-003 The block SHALL have these output stream ports:
- out_bytes  out  64  stream word; byte 0 in [63:56].
- out_byte_enables  out  8  bit 7 marks byte 0 valid.
- out_data_valid  out  1  word present.
- in_ready_for_udp_output  in  1  downstream ready; a word transfers when valid and ready are both high.
- out_error  out  1  one-cycle pulse on an unsupported command type.

Function
REQ-004 The block SHALL encode each accepted command as exactly one Sequenced Unit: an 8-byte header followed by one message, all multi-byte fields little-endian.
REQ-005 Header byte layout SHALL be: bytes 0-1 total length; byte 2 count = 0x01; byte 3 unit; bytes 4-7 sequence.
REQ-006 The Time packet SHALL be 14 bytes:
- word0 = header (length 0x000E), enables 8'hFF.
- word1 = {0x06, 0x20, seconds[7:0], [15:8], [23:16], [31:24], 0x00, 0x00}, enables 8'hFC.
REQ-007 The Delete Order packet SHALL be 22 bytes:
- word0 = header (length 0x0016), enables 8'hFF.
- word1 = {0x0E, 0x29, time_offset LE 4 bytes, order_id bytes 0-1}, enables 8'hFF.
- word2 = {order_id bytes 2-7, 0x00, 0x00}, enables 8'hFC.
REQ-008 The state machine SHALL have states IDLE, HDR, W1 and W2:
- IDLE -> HDR on accept of 0x20 or 0x29.
- HDR -> W1 on transfer.
- W1 -> IDLE on transfer for a Time packet; W1 -> W2 on transfer for a Delete Order packet.
- W2 -> IDLE on transfer.
REQ-009 out_cmd_ready SHALL be high only in IDLE, and the command fields SHALL be registered at accept.
REQ-010 out_data_valid SHALL assert on the cycle after accept (latency 1) and remain high with no gaps while in_ready_for_udp_output is high.
REQ-011 While out_data_valid is high and in_ready_for_udp_output is low, out_bytes and out_byte_enables SHALL hold stable.
REQ-012 When out_data_valid is low, out_bytes SHALL be 0 and out_byte_enables SHALL be 0.
REQ-013 The sequence counter SHALL be 32 bits, reset to 1, and increment on transfer of a packet's final word.
REQ-014 The sequence counter SHALL wrap from 0xFFFFFFFF to 0x00000001, never emitting 0.
REQ-015 An unsupported type SHALL be accepted in IDLE, produce no output, pulse out_error for one cycle, leave the sequence unchanged and leave the state in IDLE.
REQ-016 A command presented while the block is busy SHALL stall (out_cmd_ready low) and never be dropped.
REQ-017 The header unit and sequence SHALL be the values captured/current at accept, unaffected by later input changes.

Reset
REQ-018 While reset is high, the block SHALL hold state IDLE, sequence = 1, out_cmd_ready = 0, out_data_valid = 0, out_bytes = 0, out_byte_enables = 0 and out_error = 0.
REQ-019 out_cmd_ready SHALL assert on the first cycle after reset falls.
REQ-020 Reset asserted mid-packet SHALL abandon the packet immediately, with no further words, and the sequence SHALL return to 1.

Configuration
REQ-021 When macro PITCH_TX_DEBUG_EN is defined, the block SHALL add these outputs:
- out_debug_valid  out  1  debug word present.
- out_debug_element  out  64  {sequence[31:0], 8'h00, type[7:0], length[15:0]}.
- in_ready_for_debug  in  1  debug consumer ready.
REQ-022 With PITCH_TX_DEBUG_EN defined, one debug word SHALL be posted per completed packet, held until in_ready_for_debug is high; a second completion while a word is pending SHALL overwrite it.
REQ-023 Without PITCH_TX_DEBUG_EN, the debug ports and logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then two Time commands (unit 1, seconds 0x0006D219) with ready held high -> second packet is 64'h0E00010102000000/FF then 64'h062019D206000000/FC.
- Delete Order (unit 3, offset 0x11223344, id 0x0102030405060708) as first packet -> 64'h1600010301000000/FF, 64'h0E29443322110807/FF, 64'h0605040302010000/FC.
- Downstream ready low for 5 cycles mid-packet -> words held stable, no word lost or duplicated, sequence increments once.
- Type 0x55 -> out_error pulses one cycle, no output, next packet sequence unchanged.
- Sequence forced to 0xFFFFFFFF -> packet carries FF FF FF FF, next packet carries 01 00 00 00.
- Reset asserted during W1 of a Delete Order -> out_data_valid low next cycle, next packet sequence 1.
